// File: rtl/fixed_point_seq_unit_pkg.sv
// Shared definitions for the sequential fixed-point unit.
// Holds the opcode encodings used by the issuing pipeline and
// the controller state encoding, plus a small state helper.
package fixed_point_seq_unit_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] FPU_ADD  = 2'd0;
  localparam logic [OP_W-1:0] FPU_SUB  = 2'd1;
  localparam logic [OP_W-1:0] FPU_MUL  = 2'd2;
  localparam logic [OP_W-1:0] FPU_SQRT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDSUB   = 3'd1,
    ST_MUL      = 3'd2,
    ST_MUL_FIN  = 3'd3,
    ST_SQRT     = 3'd4,
    ST_SQRT_FIN = 3'd5
  } fpu_state_e;

  // Final states present a fresh result and pulse done.
  function automatic logic is_final(fpu_state_e s);
    return (s == ST_ADDSUB) || (s == ST_MUL_FIN) || (s == ST_SQRT_FIN);
  endfunction

endpackage

// File: rtl/fixed_point_seq_unit_if.sv
// Request/response bundle of the sequential fixed-point unit.
//   start, operation, operand_1, operand_2 : request (issuer -> unit)
//   busy, done, result, overflow, invalid  : status/response (unit -> issuer)
// master = issuing pipeline, slave = the unit.
interface fixed_point_seq_unit_if
  import fixed_point_seq_unit_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic                    start;
  logic [OP_W-1:0]         operation;
  logic signed [WIDTH-1:0] operand_1;
  logic signed [WIDTH-1:0] operand_2;
  logic                    busy;
  logic                    done;
  logic signed [WIDTH-1:0] result;
  logic                    overflow;
  logic                    invalid;

  modport master (
    output start, operation, operand_1, operand_2,
    input  busy, done, result, overflow, invalid
  );

  modport slave (
    input  start, operation, operand_1, operand_2,
    output busy, done, result, overflow, invalid
  );
endinterface

// File: rtl/fixed_point_seq_unit_slice_mult.sv
// Shared partial-product multiplier: unsigned SLICE x SLICE,
// purely combinational, full 2*SLICE-bit product.
//   a, b : unsigned slices
//   p    : unsigned product
module fpu_slice_multiplier
  import fixed_point_seq_unit_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0]   a,
  input  logic [SLICE-1:0]   b,
  output logic [2*SLICE-1:0] p
);

  assign p = (2*SLICE)'(a) * (2*SLICE)'(b);

endmodule

// File: rtl/fixed_point_seq_unit.sv
// Sequential fixed-point unit for the execute stage.
// Signed Q(WIDTH-FBITS).FBITS operands; add/sub/mul saturate, sqrt is
// restoring digit-by-digit. Multiply reuses one SLICE x SLICE multiplier.
// WIDTH must be a multiple of SLICE and WIDTH+FBITS must be even.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high, clears all state
//   bus   : slave side of fixed_point_seq_unit_if
//           (start/operation/operands in; busy/done/result/flags out)
// done is high in the final state; result and flags are presented
// combinationally in that cycle and held in registers afterwards.
module fixed_point_seq_unit
  import fixed_point_seq_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FBITS = 10,
  parameter int SLICE = 16
) (
  input logic                  clk,
  input logic                  reset,
  fixed_point_seq_unit_if.slave bus
);

  localparam int NS   = WIDTH / SLICE;
  localparam int IW   = (NS > 1) ? $clog2(NS) : 1;
  localparam int AW   = 2 * WIDTH;
  localparam int SHW  = $clog2(AW);
  localparam int RW   = WIDTH + FBITS;
  localparam int K    = RW / 2;
  localparam int REMW = K + 2;
  localparam int KCW  = (K > 1) ? $clog2(K) : 1;

  localparam logic [IW-1:0]    IDX_LAST = IW'(NS - 1);
  localparam logic [KCW-1:0]   K_LAST   = KCW'(K - 1);
  localparam logic [WIDTH-1:0] SMAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN     = {1'b1, {(WIDTH-1){1'b0}}};

  fpu_state_e state, next_state;

  logic [OP_W-1:0]         op_q;
  logic signed [WIDTH-1:0] a_q, b_q;
  // Unsigned magnitudes: |most negative| = 2^(WIDTH-1) still fits unsigned.
  logic [WIDTH-1:0]        mag_a, mag_b;
  logic                    neg_q;
  logic                    sq_neg_q;

  logic [IW-1:0]           idx_i, idx_j;
  logic                    issued;
  logic [SLICE-1:0]        slice_a, slice_b;
  logic [2*SLICE-1:0]      pp;
  logic [2*SLICE-1:0]      pp_p1;
  logic [SHW-1:0]          shift_p1;
  logic                    vld_p1;
  logic [AW-1:0]           acc;

  logic [RW-1:0]           rad;
  logic [REMW-1:0]         rem;
  logic [K-1:0]            root;
  logic [KCW-1:0]          sq_cnt;
  logic [REMW-1:0]         rem_shift, trial;

  logic signed [WIDTH:0]   sum_ext;
  logic [WIDTH:0]          sat_word;
  logic signed [WIDTH-1:0] res_now, result_q;
  logic                    ovf_now, inv_now, ovf_q, inv_q;
  logic                    accept;

  // Returns {overflow, value}; a disagreement between the two top bits
  // of the WIDTH+1 sum means the true value lies outside the range.
  function automatic logic [WIDTH:0] sat_addsub(logic signed [WIDTH:0] s);
    if (s[WIDTH] != s[WIDTH-1])
      return s[WIDTH] ? {1'b1, SMIN} : {1'b1, SMAX};
    return {1'b0, s[WIDTH-1:0]};
  endfunction

  // Magnitude already truncated toward zero; zero never becomes negative.
  function automatic logic [WIDTH:0] sat_mul(logic [AW-1:0] mag, logic neg);
    if (mag == '0)
      return '0;
    if (!neg) begin
      if (mag > AW'(SMAX)) return {1'b1, SMAX};
      return {1'b0, mag[WIDTH-1:0]};
    end
    if (mag > AW'(SMIN)) return {1'b1, SMIN};
    return {1'b0, WIDTH'(-mag[WIDTH-1:0])};
  endfunction

  function automatic logic [WIDTH-1:0] abs_of(logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign accept = (state == ST_IDLE) && bus.start;

  assign slice_a = mag_a[idx_i*SLICE +: SLICE];
  assign slice_b = mag_b[idx_j*SLICE +: SLICE];

  fpu_slice_multiplier #(.SLICE(SLICE)) u_slice_mult (
    .a (slice_a),
    .b (slice_b),
    .p (pp)
  );

  assign sum_ext = (op_q == FPU_SUB) ? ({a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q})
                                     : ({a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q});

  // Remainder can never exceed REMW bits, so its dropped top bits are zero.
  assign rem_shift = {rem[REMW-3:0], rad[RW-1 -: 2]};
  assign trial     = {root, 2'b01};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.operation == FPU_MUL)       next_state = ST_MUL;
          else if (bus.operation == FPU_SQRT) next_state = ST_SQRT;
          else                                next_state = ST_ADDSUB;
        end
      end
      ST_ADDSUB:   next_state = ST_IDLE;
      // One extra MUL cycle drains the last registered partial product.
      ST_MUL:      if (issued) next_state = ST_MUL_FIN;
      ST_MUL_FIN:  next_state = ST_IDLE;
      ST_SQRT:     if (sq_neg_q || (sq_cnt == K_LAST)) next_state = ST_SQRT_FIN;
      ST_SQRT_FIN: next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    sat_word = '0;
    res_now  = '0;
    ovf_now  = 1'b0;
    inv_now  = 1'b0;
    case (state)
      ST_ADDSUB: begin
        sat_word = sat_addsub(sum_ext);
        ovf_now  = sat_word[WIDTH];
        res_now  = sat_word[WIDTH-1:0];
      end
      ST_MUL_FIN: begin
        sat_word = sat_mul(acc >> FBITS, neg_q);
        ovf_now  = sat_word[WIDTH];
        res_now  = sat_word[WIDTH-1:0];
      end
      ST_SQRT_FIN: begin
        res_now = sq_neg_q ? '0 : WIDTH'(root);
        inv_now = sq_neg_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      neg_q    <= 1'b0;
      sq_neg_q <= 1'b0;
      idx_i    <= '0;
      idx_j    <= '0;
      issued   <= 1'b0;
      pp_p1    <= '0;
      shift_p1 <= '0;
      vld_p1   <= 1'b0;
      acc      <= '0;
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      sq_cnt   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= bus.operation;
            a_q      <= bus.operand_1;
            b_q      <= bus.operand_2;
            mag_a    <= abs_of(bus.operand_1);
            mag_b    <= abs_of(bus.operand_2);
            neg_q    <= bus.operand_1[WIDTH-1] ^ bus.operand_2[WIDTH-1];
            sq_neg_q <= bus.operand_1[WIDTH-1];
            rad      <= {bus.operand_1, {FBITS{1'b0}}};
            rem      <= '0;
            root     <= '0;
            sq_cnt   <= '0;
            acc      <= '0;
            idx_i    <= '0;
            idx_j    <= '0;
            issued   <= 1'b0;
            vld_p1   <= 1'b0;
          end
        end
        ST_MUL: begin
          // Stage p1: registered partial product and its weight.
          if (!issued) begin
            pp_p1    <= pp;
            shift_p1 <= SHW'(SLICE) * (SHW'(idx_i) + SHW'(idx_j));
            vld_p1   <= 1'b1;
            if (idx_i == IDX_LAST) begin
              idx_i <= '0;
              if (idx_j == IDX_LAST) issued <= 1'b1;
              else                   idx_j  <= idx_j + 1'b1;
            end else begin
              idx_i <= idx_i + 1'b1;
            end
          end else begin
            vld_p1 <= 1'b0;
          end
          // Stage p2: weighted accumulation.
          if (vld_p1)
            acc <= acc + (AW'(pp_p1) << shift_p1);
        end
        ST_SQRT: begin
          if (!sq_neg_q) begin
            rad    <= rad << 2;
            sq_cnt <= sq_cnt + 1'b1;
            if (rem_shift >= trial) begin
              rem  <= rem_shift - trial;
              root <= {root[K-2:0], 1'b1};
            end else begin
              rem  <= rem_shift;
              root <= {root[K-2:0], 1'b0};
            end
          end
        end
        ST_ADDSUB, ST_MUL_FIN, ST_SQRT_FIN: begin
          result_q <= res_now;
          ovf_q    <= ovf_now;
          inv_q    <= inv_now;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy     = (state != ST_IDLE);
    bus.done     = is_final(state);
    bus.result   = is_final(state) ? res_now : result_q;
    bus.overflow = is_final(state) ? ovf_now : ovf_q;
    bus.invalid  = is_final(state) ? inv_now : inv_q;
  end

endmodule
